// File: rtl/matrix_key_scan.sv
// 4x4 active-low key matrix scanner with frame-level debounce.
// Reports single key presses as {row,col} with a one-cycle strobe.
module matrix_key_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] KEY_COL,
  input  logic [3:0] KEY_ROW,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_FRAMES);
  // bit 4 set means "no key"; bits 3:0 hold {row,col}
  localparam logic [4:0] NONE = 5'h10;

  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [15:0]   fmap;
  logic [4:0]    cand;
  logic [4:0]    stable;
  logic [3:0]    cnt;

  logic          tick;
  logic          frame_end;
  logic [3:0]    pressed;
  logic [15:0]   map_full;
  logic [4:0]    ones;
  logic [3:0]    one_idx;
  logic          multi;
  logic [4:0]    fcand;
  logic [3:0]    cnt_n;
  logic          accept;

  assign tick      = (div == DIV_MAX);
  assign frame_end = tick && (col == 2'd3);
  assign pressed   = ~row_s2;

  // map is indexed col*4+row
  always_comb begin
    map_full = fmap | (16'(pressed) << {col, 2'b00});
  end

  always_comb begin
    ones    = '0;
    one_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (map_full[i]) begin
        ones    = ones + 5'd1;
        one_idx = 4'(i);
      end
    end
  end

  always_comb begin
    multi = (ones > 5'd1);
    fcand = NONE;
    if (ones == 5'd1)
      fcand = {1'b0, one_idx[1:0], one_idx[3:2]};
  end

  always_comb begin
    cnt_n = 4'd1;
    if (fcand == cand)
      cnt_n = (cnt >= DB_MAX) ? DB_MAX : cnt + 4'd1;
    accept = frame_end && !multi &&
             (cnt_n == DB_MAX) && (fcand != stable);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= KEY_ROW;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      col     <= '0;
      KEY_COL <= 4'b1110;
      fmap    <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        col     <= col + 2'd1;
        KEY_COL <= ~(4'b0001 << (col + 2'd1));
        fmap    <= frame_end ? '0 : map_full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= NONE;
      stable <= NONE;
      cnt    <= '0;
    end else if (frame_end && !multi) begin
      cand <= fcand;
      cnt  <= cnt_n;
      if (accept)
        stable <= fcand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (accept) begin
        if (fcand[4]) begin
          key_down <= 1'b0;
        end else begin
          key_code  <= fcand[3:0];
          key_valid <= 1'b1;
          key_down  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan: directed plan plus random key traffic
// checked every cycle against a frame-level reference model.
module tb_matrix_key_scan;

  localparam int SD = 4;
  localparam int DF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] KEY_COL;
  logic [3:0] KEY_ROW;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  // keys[r*4+c] = key at row r, column c is pressed
  logic [15:0] keys = '0;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  always_comb begin
    KEY_ROW = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && KEY_COL[c] === 1'b0)
          KEY_ROW[r] = 1'b0;
  end

  matrix_key_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .KEY_COL(KEY_COL),
    .KEY_ROW(KEY_ROW),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the scanner sees column c as it was two cycles
  // before that column's sample point; frames are debounced as sets.
  int          mk;
  logic [15:0] kd1, kd2, frame;
  int          cand, stable, cnt, c, n, fc;
  logic        e_valid, e_down;
  logic [3:0]  e_code, e_col;
  bit          armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      mk = 0; kd1 = '0; kd2 = '0; frame = '0;
      cand = 16; stable = 16; cnt = 0;
      e_valid = 1'b0; e_down = 1'b0; e_code = '0;
      e_col = 4'b1110; armed = 1;
    end else begin
      c = (mk / SD) % 4;
      e_valid = 1'b0;
      if (mk % SD == SD - 1) begin
        for (int r = 0; r < 4; r++)
          if (kd2[r*4+c]) frame[r*4+c] = 1'b1;
        if (c == 3) begin
          n = $countones(frame);
          fc = 16;
          for (int i = 0; i < 16; i++)
            if (frame[i]) fc = i;
          if (n <= 1) begin
            if (fc == cand) cnt = (cnt < DF) ? cnt + 1 : DF;
            else begin cnt = 1; cand = fc; end
            if (cnt == DF && cand != stable) begin
              stable = cand;
              if (cand == 16) e_down = 1'b0;
              else begin
                e_code = 4'(cand); e_valid = 1'b1; e_down = 1'b1;
              end
            end
          end
          frame = '0;
        end
      end
      kd2 = kd1;
      kd1 = keys;
      mk++;
      e_col = ~(4'b0001 << ((mk / SD) % 4));
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("mdl_key_valid", 32'(key_valid), 32'(e_valid));
      check("mdl_key_down", 32'(key_down), 32'(e_down));
      check("mdl_key_code", 32'(key_code), 32'(e_code));
      check("mdl_KEY_COL", 32'(KEY_COL), 32'(e_col));
      if (key_valid === 1'b1) pulses++;
    end
  end

  task automatic cyc(int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(int bound, output int lat);
    int p0;
    p0 = pulses;
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      cyc(1);
      if (pulses != p0) begin lat = i; break; end
    end
  endtask

  task automatic wait_down(logic v, int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      cyc(1);
      if (key_down === v) begin lat = i; break; end
    end
  endtask

  int lat, p0, dur, mode;
  logic [15:0] rk;

  initial begin
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("t1_col0", 32'(KEY_COL), 32'(4'b1110));
    check("t1_code", 32'(key_code), 32'(4'h0));
    check("t1_valid", 32'(key_valid), 32'(1'b0));
    check("t1_down", 32'(key_down), 32'(1'b0));
    cyc(4); check("t1_col1", 32'(KEY_COL), 32'(4'b1101));
    cyc(4); check("t1_col2", 32'(KEY_COL), 32'(4'b1011));
    cyc(4); check("t1_col3", 32'(KEY_COL), 32'(4'b0111));
    cyc(4); check("t1_colw", 32'(KEY_COL), 32'(4'b1110));

    p0 = pulses;
    keys = 16'(1) << 9;
    cyc(10);
    keys = '0;
    cyc(40);
    check("t3_pulses", 32'(pulses - p0), 32'(0));
    check("t3_down", 32'(key_down), 32'(1'b0));
    check("t3_code", 32'(key_code), 32'(4'h0));

    p0 = pulses;
    keys = 16'(1) << 9;
    wait_pulse(60, lat);
    check("t2_latency_ok", 32'(lat >= 1 && lat <= 51), 32'(1));
    check("t2_code", 32'(key_code), 32'(4'h9));
    if (lat > 0) cyc(100 - lat);
    check("t2_one_pulse", 32'(pulses - p0), 32'(1));
    check("t2_down", 32'(key_down), 32'(1'b1));

    keys = '0;
    wait_down(1'b0, 60, lat);
    check("t4_release_ok", 32'(lat >= 1 && lat <= 51), 32'(1));
    check("t4_code_hold", 32'(key_code), 32'(4'h9));
    keys = 16'(1) << 3;
    wait_pulse(60, lat);
    check("t4_press_ok", 32'(lat > 0), 32'(1));
    check("t4_code", 32'(key_code), 32'(4'h3));
    keys = '0;
    wait_down(1'b0, 60, lat);
    check("t4_up_ok", 32'(lat > 0), 32'(1));

    p0 = pulses;
    keys = (16'(1) << 0) | (16'(1) << 15);
    cyc(80);
    check("t5_ghost_pulses", 32'(pulses - p0), 32'(0));
    check("t5_down", 32'(key_down), 32'(1'b0));
    check("t5_code", 32'(key_code), 32'(4'h3));
    keys = 16'(1) << 0;
    wait_pulse(60, lat);
    check("t5_single_ok", 32'(lat > 0), 32'(1));
    check("t5_code0", 32'(key_code), 32'(4'h0));
    keys = '0;
    wait_down(1'b0, 60, lat);

    keys = 16'(1) << 6;
    wait_down(1'b1, 60, lat);
    check("t6_held_ok", 32'(lat > 0), 32'(1));
    check("t6_code", 32'(key_code), 32'(4'h6));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6_rst_down", 32'(key_down), 32'(1'b0));
    check("t6_rst_code", 32'(key_code), 32'(4'h0));
    check("t6_rst_col", 32'(KEY_COL), 32'(4'b1110));
    check("t6_rst_valid", 32'(key_valid), 32'(1'b0));
    wait_pulse(60, lat);
    check("t6_again_ok", 32'(lat > 0), 32'(1));
    check("t6_code_again", 32'(key_code), 32'(4'h6));
    keys = '0;
    wait_down(1'b0, 60, lat);

    repeat (40) begin
      mode = $urandom_range(0, 3);
      dur = $urandom_range(1, 60);
      rk = '0;
      case (mode)
        1, 3: rk[$urandom_range(0, 15)] = 1'b1;
        2: begin
          rk[$urandom_range(0, 15)] = 1'b1;
          rk[$urandom_range(0, 15)] = 1'b1;
        end
        default: rk = '0;
      endcase
      if (mode == 3) dur = $urandom_range(1, 12);
      keys = rk;
      cyc(dur);
    end
    keys = '0;
    cyc(60);
    check("end_down", 32'(key_down), 32'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_key_scan.md
Name: matrix_key_scan

Overview:
- Scans a 4x4 active-low button matrix: drives one column low at a time, reads the rows back, debounces, and reports single key presses as a 4-bit code with a one-cycle valid strobe.
- It is the input-side counterpart of the multiplexed 7-segment display scanner: the display drives AN out one digit at a time, and this block drives KEY_COL out and samples KEY_ROW in.
- Its key_code/key_valid outputs feed the number-entry logic that supplies the 16-bit display value.

Parameters:
- SCAN_DIV, 50000: clk cycles per column. Minimum 4, so the synchronized rows settle before sampling.
- DEBOUNCE_FRAMES, 2: consecutive identical full-matrix frames needed to accept a change. Range 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- KEY_COL  output  4  column drive, active-low; exactly one bit low at all times
- KEY_ROW  input  4  row sense, active-low, externally pulled up, asynchronous
- key_code  output  4  code of last accepted key = {row[1:0], col[1:0]}
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_down  output  1  level; 1 while the accepted key is stably held

Behaviour:
- Reset is synchronous: on a clk edge with rst=1 all state clears.
  - Outputs: KEY_COL=4'b1110, key_code=0, key_valid=0, key_down=0.
  - Internals: div=0, col=0, row sync flops=4'b1111, frame map=0, candidate=NONE, stable=NONE, debounce count=0.
  - Reset mid-press emits no pulse. A key still held after reset is reported again after a full debounce.
- Row sync: KEY_ROW passes through 2 flops; only the synced value is used.
- Divider: div counts 0..SCAN_DIV-1. tick=1 when div==SCAN_DIV-1, then div wraps to 0.
- Column advance: on tick, the synced rows are sampled for the current col, then col increments 0,1,2,3,0.
  - KEY_COL = ~(1<<col). It is registered and updates the cycle after tick.
- Frame map: each tick ORs the pressed bits into map[col*4+row], where pressed means synced row bit == 0.
- Frame end: a tick with col==3. The frame's candidate is:
  - 0 bits set: NONE.
  - exactly 1 bit set: code {row,col}.
  - 2 or more bits set: ghost/multi-press; the frame is discarded, with count, candidate and stable unchanged.
  - The map clears for the next frame.
- Debounce, applied at each non-discarded frame end:
  - If the frame candidate equals the previous candidate, count increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise count=1 and previous candidate = frame candidate.
  - Accept when count reaches DEBOUNCE_FRAMES and candidate != stable; stable <= candidate.
- Accept actions, registered in the cycle after the frame-end tick:
  - NONE -> key k: key_code<=k, key_valid=1 for exactly one cycle, key_down<=1.
  - key k -> NONE: key_down<=0, key_code holds k, no pulse.
  - key j -> key k, direct change: key_code<=k, one key_valid pulse, key_down stays 1.
- No auto-repeat: a held key produces exactly one pulse.
- Latency: frame = 4*SCAN_DIV cycles. A press held from before frame start is accepted after DEBOUNCE_FRAMES frames, plus at most 1 frame of alignment, plus 3 cycles of sync/register delay.
- key_valid is never high in consecutive cycles. At most one accept happens per frame.
- All widths are fixed.
  - div is sized to clog2(SCAN_DIV).
  - count is 4 bits, saturating.
  - No arithmetic overflow is possible elsewhere.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=2, frame=16 cycles; bench matrix model pulls ROW[r] low when KEY_COL[c]==0 and key (r,c) is pressed):
1. Assert rst 3 cycles, release -> KEY_COL=1110, key_code=0, key_valid=0, key_down=0. Then KEY_COL goes 1101, 1011, 0111, 1110 at 4-cycle intervals.
2. Press (r=2,c=1) and hold 100 cycles -> exactly one key_valid pulse with key_code=4'h9, within 51 cycles of press. key_down=1 for the rest of the hold; no second pulse.
3. Press (2,1) for 10 cycles only (bounce) -> no key_valid, key_down stays 0, key_code stays 0.
4. With 4'h9 accepted, release -> key_down=0 within 51 cycles, key_code stays 9. Then press (0,3) -> one pulse, key_code=4'h3.
5. Press (0,0) and (3,3) together for 80 cycles -> no pulse, key_down and key_code unchanged. Release (3,3) while holding (0,0) -> one pulse, key_code=4'h0.
6. Hold (1,2) until key_down=1, assert rst 1 cycle -> next cycle key_down=0, key_code=0, KEY_COL=1110. Keep holding -> one new pulse with key_code=4'h6 after debounce.
